// File: rtl/sram_bridge_sync.sv
// Clocked ARM-EBI to asynchronous SRAM bridge: synchronises the ARM strobes, runs
// its own SRAM cycle with setup/strobe/hold timing and stretches the ARM cycle via ARM_nWAIT.
module sram_bridge_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int SYNC_STAGES = 2,
  parameter int RD_WAIT     = 2,
  parameter int WR_WAIT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] ARM_D,
  input  logic [ADDR_WIDTH-1:0] ARM_A,
  input  logic                  ARM_nCS,
  input  logic                  ARM_nOE,
  input  logic                  ARM_nWE,
  output logic                  ARM_nWAIT,
  inout  wire  [DATA_WIDTH-1:0] SRAM_D,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic                  SRAM_nCS,
  output logic                  SRAM_nOE,
  output logic                  SRAM_nWE,
  output logic                  busy
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, DONE
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    drive_q;
  logic                    wr_q;
  logic                    armed_q;
  logic                    ncs_q, noe_q, nwe_q, nwait_q;
  logic [SYNC_STAGES-1:0]  ncs_sync_q, noe_sync_q, nwe_sync_q;
  logic                    cs_s, oe_s, we_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ncs_sync_q <= '1;
      noe_sync_q <= '1;
      nwe_sync_q <= '1;
    end else begin
      ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], ARM_nCS};
      noe_sync_q <= {noe_sync_q[SYNC_STAGES-2:0], ARM_nOE};
      nwe_sync_q <= {nwe_sync_q[SYNC_STAGES-2:0], ARM_nWE};
    end
  end

  assign cs_s = ncs_sync_q[SYNC_STAGES-1];
  assign oe_s = noe_sync_q[SYNC_STAGES-1];
  assign we_s = nwe_sync_q[SYNC_STAGES-1];

  // armed_q blocks a restart until every strobe has been seen high after a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drive_q <= 1'b0;
      wr_q    <= 1'b0;
      armed_q <= 1'b1;
      ncs_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      nwait_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_s && oe_s && we_s) armed_q <= 1'b1;
          if (armed_q && !cs_s && (!we_s || !oe_s)) begin
            armed_q <= 1'b0;
            addr_q  <= ARM_A;
            ncs_q   <= 1'b0;
            nwait_q <= 1'b0;
            if (!we_s) begin
              wdata_q <= ARM_D;
              drive_q <= 1'b1;
              wr_q    <= 1'b1;
              state_q <= W_SETUP;
            end else begin
              wr_q    <= 1'b0;
              state_q <= R_SETUP;
            end
          end
        end
        W_SETUP: begin
          nwe_q   <= 1'b0;
          cnt_q   <= CNT_W'(WR_WAIT);
          state_q <= W_STROBE;
        end
        W_STROBE: begin
          if (cnt_q == CNT_W'(1)) begin
            nwe_q   <= 1'b1;
            state_q <= W_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        W_HOLD: begin
          ncs_q   <= 1'b1;
          drive_q <= 1'b0;
          nwait_q <= 1'b1;
          state_q <= DONE;
        end
        R_SETUP: begin
          noe_q   <= 1'b0;
          cnt_q   <= CNT_W'(RD_WAIT);
          state_q <= R_STROBE;
        end
        R_STROBE: begin
          if (cnt_q == CNT_W'(1)) begin
            rdata_q <= SRAM_D;
            noe_q   <= 1'b1;
            ncs_q   <= 1'b1;
            nwait_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (cs_s || (oe_s && we_s)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SRAM_A    = addr_q;
  assign SRAM_nCS  = ncs_q;
  assign SRAM_nOE  = noe_q;
  assign SRAM_nWE  = nwe_q;
  assign ARM_nWAIT = nwait_q;
  assign busy      = (state_q != IDLE);

  // ARM_D follows the raw strobes so it releases as soon as the ARM deasserts nOE/nCS
  assign ARM_D  = (state_q == DONE && !wr_q && !ARM_nCS && !ARM_nOE) ? rdata_q : 'z;
  assign SRAM_D = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_bridge_sync.sv
// Bench for sram_bridge_sync: SRAM behavioural model, ARM-side tasks and
// queue-based expected data for SRAM writes and ARM reads.
module tb_sram_bridge_sync;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] arm_a = '0;
  logic          arm_ncs = 1'b1, arm_noe = 1'b1, arm_nwe = 1'b1;
  logic          arm_drv = 1'b0;
  logic [7:0]    arm_wdat = '0;
  tri1  [7:0]    arm_d;
  tri1  [7:0]    sram_d;
  wire           arm_nwait, sram_ncs, sram_noe, sram_nwe, busy;
  wire  [AW-1:0] sram_a;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    shadow [logic [AW-1:0]];
  logic [7:0]    rd_exp_q [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [7:0]    wr_data_q [$];
  int            tests_run = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  sram_bridge_sync dut (
    .clk(clk), .reset(reset),
    .ARM_D(arm_d), .ARM_A(arm_a), .ARM_nCS(arm_ncs), .ARM_nOE(arm_noe), .ARM_nWE(arm_nwe),
    .ARM_nWAIT(arm_nwait),
    .SRAM_D(sram_d), .SRAM_A(sram_a), .SRAM_nCS(sram_ncs), .SRAM_nOE(sram_noe), .SRAM_nWE(sram_nwe),
    .busy(busy)
  );

  // Idle buses float high through tri1, so a released bus reads 8'hFF
  assign arm_d  = arm_drv ? arm_wdat : 'z;
  assign sram_d = (!sram_ncs && !sram_noe) ? mem[sram_a] : 'z;
  always @(posedge sram_nwe) if (!sram_ncs) mem[sram_a] = sram_d;

  task automatic release_all();
    int c;
    @(negedge clk);
    arm_ncs = 1'b1; arm_noe = 1'b1; arm_nwe = 1'b1; arm_drv = 1'b0;
    for (c = 0; c < 20; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL release_idle: busy=%b required 0", busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic arm_write(input logic [AW-1:0] a, input logic [7:0] d,
                           output int nwe_lo, output int nwait_lo, output int ncs_lo, output int bad_bus);
    bit seen;
    seen = 0; nwe_lo = 0; nwait_lo = 0; ncs_lo = 0; bad_bus = 0;
    @(negedge clk);
    arm_a = a; arm_wdat = d; arm_drv = 1'b1; arm_ncs = 1'b0; arm_nwe = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_nwe) nwe_lo++;
      if (!sram_ncs) begin
        ncs_lo++;
        if (sram_a !== a || sram_d !== d) bad_bus++;
      end
      if (!arm_nwait) begin
        nwait_lo++; seen = 1;
      end else if (seen) break;
    end
  endtask

  task automatic arm_read(input logic [AW-1:0] a, output int noe_lo, output int nwait_lo,
                          output logic [7:0] got);
    bit seen;
    seen = 0; noe_lo = 0; nwait_lo = 0; got = '0;
    rd_exp_q.push_back(shadow[a]);
    @(negedge clk);
    arm_a = a; arm_drv = 1'b0; arm_ncs = 1'b0; arm_noe = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_noe) noe_lo++;
      if (!arm_nwait) begin
        nwait_lo++; seen = 1;
      end else if (seen) begin
        got = arm_d;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      arm_ncs = i[0]; arm_noe = i[1]; arm_nwe = ~i[0];
      @(negedge clk);
      tests_run++;
      if ({sram_ncs, sram_noe, sram_nwe, arm_nwait, busy} !== 5'b11110 ||
          arm_d !== 8'hFF || sram_d !== 8'hFF) begin
        fails++;
        $display("FAIL reset_state[%0d]: ncs/noe/nwe/nwait/busy=%b arm_d=%h sram_d=%h required 11110 ff ff",
                 i, {sram_ncs, sram_noe, sram_nwe, arm_nwait, busy}, arm_d, sram_d);
      end
    end
    arm_ncs = 1'b1; arm_noe = 1'b1; arm_nwe = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int nwe_lo, nwait_lo, ncs_lo, bad;
    logic [AW-1:0] ea;
    logic [7:0] ed;
    wr_addr_q.push_back(19'h12345); wr_data_q.push_back(8'hA5);
    shadow[19'h12345] = 8'hA5;
    arm_write(19'h12345, 8'hA5, nwe_lo, nwait_lo, ncs_lo, bad);
    tests_run++;
    if (nwe_lo != 2) begin fails++; $display("FAIL write_nwe_low: got %0d clks required 2", nwe_lo); end
    tests_run++;
    if (nwait_lo != 4) begin fails++; $display("FAIL write_nwait_low: got %0d clks required 4", nwait_lo); end
    tests_run++;
    if (ncs_lo != 4) begin fails++; $display("FAIL write_ncs_low: got %0d clks required 4", ncs_lo); end
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL write_addr_data: %0d bad cycles required 0", bad); end
    tests_run++;
    if ({sram_ncs, sram_nwe, busy} !== 3'b111 || sram_d !== 8'hFF) begin
      fails++;
      $display("FAIL write_done_state: ncs/nwe/busy=%b sram_d=%h required 111 ff",
               {sram_ncs, sram_nwe, busy}, sram_d);
    end
    release_all();
    ea = wr_addr_q.pop_front(); ed = wr_data_q.pop_front();
    tests_run++;
    if (mem[ea] !== ed) begin fails++; $display("FAIL write_sram_content: got %h required %h", mem[ea], ed); end
  endtask

  task automatic test_read();
    int noe_lo, nwait_lo;
    logic [7:0] got, exp;
    arm_read(19'h00010, noe_lo, nwait_lo, got);
    exp = rd_exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin fails++; $display("FAIL read_data: got %h required %h", got, exp); end
    tests_run++;
    if (noe_lo != 2) begin fails++; $display("FAIL read_noe_low: got %0d clks required 2", noe_lo); end
    tests_run++;
    if (nwait_lo != 3) begin fails++; $display("FAIL read_nwait_low: got %0d clks required 3", nwait_lo); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (arm_d !== exp) begin fails++; $display("FAIL read_data_held: got %h required %h", arm_d, exp); end
    arm_noe = 1'b1;
    #1;
    tests_run++;
    if (arm_d !== 8'hFF) begin fails++; $display("FAIL read_release: got %h required ff", arm_d); end
    release_all();
  endtask

  task automatic test_back_to_back();
    int nwe_lo, nwait_lo, ncs_lo, bad, noe_lo, restarts;
    logic [7:0] got, exp;
    shadow[19'h7FFFF] = 8'h55;
    arm_write(19'h7FFFF, 8'h55, nwe_lo, nwait_lo, ncs_lo, bad);
    tests_run++;
    if (nwe_lo != 2 || bad != 0) begin
      fails++; $display("FAIL b2b_write: nwe_low=%0d bad=%0d required 2 0", nwe_lo, bad);
    end
    @(negedge clk);
    arm_ncs = 1'b1; arm_drv = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_done_exit: busy=%b required 0", busy); end
    arm_ncs = 1'b0;
    restarts = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || sram_nwe !== 1'b1 || arm_nwait !== 1'b1) restarts++;
    end
    tests_run++;
    if (restarts != 0) begin fails++; $display("FAIL b2b_no_restart: %0d busy cycles required 0", restarts); end
    release_all();
    arm_read(19'h7FFFF, noe_lo, nwait_lo, got);
    exp = rd_exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin fails++; $display("FAIL b2b_read_data: got %h required %h", got, exp); end
    release_all();
  endtask

  task automatic test_reset_mid_write();
    int c;
    @(negedge clk);
    arm_a = 19'h00ABC; arm_wdat = 8'h99; arm_drv = 1'b1; arm_ncs = 1'b0; arm_nwe = 1'b0;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!sram_nwe) break;
    end
    tests_run++;
    if (sram_nwe !== 1'b0) begin fails++; $display("FAIL midrst_reach_strobe: nwe=%b required 0", sram_nwe); end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({sram_ncs, sram_nwe, sram_noe, arm_nwait, busy} !== 5'b11110 || sram_d !== 8'hFF) begin
      fails++;
      $display("FAIL midrst_state: ncs/nwe/noe/nwait/busy=%b sram_d=%h required 11110 ff",
               {sram_ncs, sram_nwe, sram_noe, arm_nwait, busy}, sram_d);
    end
    @(negedge clk);
    arm_ncs = 1'b1; arm_nwe = 1'b1; arm_drv = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    release_all();
  endtask

  task automatic test_abort();
    int noe_lo, done_cnt, bad;
    bit aborted;
    noe_lo = 0; done_cnt = 0; bad = 0; aborted = 0;
    @(negedge clk);
    arm_a = 19'h00010; arm_drv = 1'b0; arm_ncs = 1'b0; arm_noe = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!sram_noe) begin
        noe_lo++;
        if (!aborted) begin aborted = 1; arm_ncs = 1'b1; end
      end
      if (busy && sram_ncs) done_cnt++;
      if (aborted && arm_d !== 8'hFF) bad++;
      if (aborted && !busy) break;
    end
    tests_run++;
    if (noe_lo != 2) begin fails++; $display("FAIL abort_noe_low: got %0d clks required 2", noe_lo); end
    tests_run++;
    if (done_cnt != 1) begin fails++; $display("FAIL abort_done_len: got %0d clks required 1", done_cnt); end
    tests_run++;
    if (bad != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_arm_d_z: %0d driven cycles busy=%b required 0 0", bad, busy);
    end
    release_all();
  endtask

  initial begin
    mem[19'h00010] = 8'h3C;
    shadow[19'h00010] = 8'h3C;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_write();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
